// File: rtl/medevac_sensor_qualifier.sv
// Sensor/ACK front end for medevac_fsm: 2-flop sync, asymmetric persistence debounce
// on sample_en, and a post-reset warm-up that holds every qualified flag low.
module medevac_sensor_qualifier #(
  parameter int CNT_W   = 4,
  parameter int ON_CNT  = 4,
  parameter int OFF_CNT = 8,
  parameter int ACK_CNT = 3,
  parameter int WARMUP  = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw_st,
  input  logic raw_hs,
  input  logic raw_oc,
  input  logic raw_cs,
  input  logic raw_im,
  input  logic raw_ws,
  input  logic raw_ack,
  output logic ST,
  output logic HS,
  output logic OC,
  output logic CS,
  output logic IM,
  output logic WS,
  output logic ACK,
  output logic ack_pulse,
  output logic ready
);

  // state  | meaning
  // S_WARM | counting sample_en pulses, all flags forced to 0
  // S_RUN  | warm-up done, channels debounce normally until rst
  typedef enum logic [0:0] {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int NCH   = 7;
  localparam int ACK_I = 6;

  localparam logic [CNT_W-1:0] ON_TC   = CNT_W'(ON_CNT - 1);
  localparam logic [CNT_W-1:0] OFF_TC  = CNT_W'(OFF_CNT - 1);
  localparam logic [CNT_W-1:0] ACK_TC  = CNT_W'(ACK_CNT - 1);
  localparam logic [CNT_W-1:0] WARM_TC = CNT_W'(WARMUP - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;

  logic [NCH-1:0] raw_vec;
  logic [NCH-1:0] sync1, sync2;
  logic [NCH-1:0] flag, flag_nxt;
  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];
  logic [CNT_W-1:0] tc;
  logic ack_pulse_q, ack_pulse_nxt;

  assign raw_vec = {raw_ack, raw_ws, raw_im, raw_cs, raw_oc, raw_hs, raw_st};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WARM;
      wcnt        <= '0;
      sync1       <= '0;
      sync2       <= '0;
      flag        <= '0;
      ack_pulse_q <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      sync1       <= raw_vec;
      sync2       <= sync1;
      flag        <= flag_nxt;
      ack_pulse_q <= ack_pulse_nxt;
      for (int i = 0; i < NCH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_WARM: begin
        if (sample_en) begin
          wcnt_nxt = wcnt + CNT_W'(1);
          if (wcnt == WARM_TC) state_nxt = S_RUN;
        end
      end
      S_RUN: state_nxt = S_RUN;
      default: state_nxt = S_WARM;
    endcase
  end

  // Threshold depends on the channel and on the direction the flag would move.
  always_comb begin
    flag_nxt = flag;
    cnt_nxt  = cnt;
    tc       = '0;
    if (sample_en && (state == S_RUN)) begin
      for (int i = 0; i < NCH; i++) begin
        if (i == ACK_I) tc = ACK_TC;
        else            tc = flag[i] ? OFF_TC : ON_TC;
        if (sync2[i] == flag[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == tc) begin
          flag_nxt[i] = ~flag[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    ack_pulse_nxt = flag_nxt[ACK_I] & ~flag[ACK_I];
  end

  assign ST        = flag[0];
  assign HS        = flag[1];
  assign OC        = flag[2];
  assign CS        = flag[3];
  assign IM        = flag[4];
  assign WS        = flag[5];
  assign ACK       = flag[ACK_I];
  assign ack_pulse = ack_pulse_q;
  assign ready     = (state == S_RUN);

endmodule

// File: tb/tb_medevac_sensor_qualifier.sv
// Bench for medevac_sensor_qualifier: reset/warm-up vector table, hand sequences for the
// debounce corner cases, then random stimulus against a run-length reference model.
module tb_medevac_sensor_qualifier;

  logic clk = 1'b0;
  logic rst, sample_en;
  logic raw_st, raw_hs, raw_oc, raw_cs, raw_im, raw_ws, raw_ack;
  logic ST, HS, OC, CS, IM, WS, ACK, ack_pulse, ready;

  medevac_sensor_qualifier dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .raw_st(raw_st), .raw_hs(raw_hs), .raw_oc(raw_oc), .raw_cs(raw_cs),
    .raw_im(raw_im), .raw_ws(raw_ws), .raw_ack(raw_ack),
    .ST(ST), .HS(HS), .OC(OC), .CS(CS), .IM(IM), .WS(WS), .ACK(ACK),
    .ack_pulse(ack_pulse), .ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // bit order: 0 st, 1 hs, 2 oc, 3 cs, 4 im, 5 ws, 6 ack
  logic [6:0] raw;

  logic [6:0] m_s1, m_s2, m_flag;
  int         m_run [7];
  int         m_w;
  logic       m_ready, m_pulse;

  typedef struct {
    logic       rst;
    logic       se;
    logic [6:0] raw;
    logic       exp_ready;
    logic       exp_oc;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int need(input int c, input logic f);
    if (c == 6) return 3;
    return f ? 8 : 4;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_flag = '0; m_w = 0; m_ready = 0; m_pulse = 0;
    for (int c = 0; c < 7; c++) m_run[c] = 0;
  endtask

  task automatic model_step(input logic r, input logic se, input logic [6:0] rv);
    logic p;
    if (r) begin
      model_reset();
    end else begin
      p = 1'b0;
      if (se && m_ready) begin
        for (int c = 0; c < 7; c++) begin
          if (m_s2[c] != m_flag[c]) begin
            m_run[c]++;
            if (m_run[c] == need(c, m_flag[c])) begin
              m_flag[c] = ~m_flag[c];
              m_run[c]  = 0;
              if (c == 6 && m_flag[6]) p = 1'b1;
            end
          end else begin
            m_run[c] = 0;
          end
        end
      end
      if (se && !m_ready) begin
        m_w++;
        if (m_w == 15) m_ready = 1'b1;
      end
      m_s2    = m_s1;
      m_s1    = rv;
      m_pulse = p;
    end
  endtask

  task automatic cycle(input logic r, input logic se);
    rst = r; sample_en = se;
    {raw_ack, raw_ws, raw_im, raw_cs, raw_oc, raw_hs, raw_st} = raw;
    @(posedge clk);
    model_step(r, se, raw);
    @(negedge clk);
    chk("model", {7'd0, ready, ack_pulse, ACK, WS, IM, CS, OC, HS, ST},
                 {7'd0, m_ready, m_pulse, m_flag});
  endtask

  initial begin
    int first;
    int pulses;
    logic st_seen;
    model_reset();
    raw = '0;

    // 1: reset with raw_oc high, sample every cycle
    for (int k = 0; k < 21; k++) begin
      vecs[k].rst       = (k == 0);
      vecs[k].se        = 1'b1;
      vecs[k].raw       = 7'b000_0100;
      vecs[k].exp_ready = (k >= 15);
      vecs[k].exp_oc    = (k >= 19);
    end
    for (int k = 0; k < 21; k++) begin
      raw = vecs[k].raw;
      cycle(vecs[k].rst, vecs[k].se);
      chk("t1_ready", {15'd0, ready}, {15'd0, vecs[k].exp_ready});
      chk("t1_oc",    {15'd0, OC},    {15'd0, vecs[k].exp_oc});
    end
    chk("t1_reset_others", {9'd0, ST, HS, CS, IM, WS, ACK, ack_pulse}, 16'd0);

    // 2: 3-sample glitch on raw_st must not raise ST, and must leave the count cleared
    st_seen = 1'b0;
    for (int n = 0; n < 14; n++) begin
      raw[0] = (n < 3);
      cycle(1'b0, 1'b1);
      if (ST) st_seen = 1'b1;
    end
    chk("t2_st_glitch", {15'd0, st_seen}, 16'd0);
    first = -1;
    for (int n = 0; n < 16; n++) begin
      raw[0] = (n < 4);
      cycle(1'b0, 1'b1);
      if (ST && first < 0) first = n;
    end
    chk("t2_st_rise_at", 16'(first), 16'd5);

    // 3: OC drop needs 8 consecutive zeros; a single 1 restarts the run
    first = -1;
    for (int n = 0; n < 22; n++) begin
      raw[2] = (n == 7);
      cycle(1'b0, 1'b1);
      if (!OC && first < 0) first = n;
    end
    chk("t3_oc_drop_at", 16'(first), 16'd17);

    // 4: bouncy ACK button
    first = -1; pulses = 0;
    for (int n = 0; n < 25; n++) begin
      raw[6] = (n != 1);
      cycle(1'b0, 1'b1);
      if (ACK && first < 0) first = n;
      if (ack_pulse) begin
        pulses++;
        chk("t4_pulse_cycle", 16'(n), 16'd6);
      end
    end
    chk("t4_ack_rise_at", 16'(first), 16'd6);
    chk("t4_pulse_count", 16'(pulses), 16'd1);
    chk("t4_ack_held", {15'd0, ACK}, 16'd1);

    // 5: sparse strobes, raw_ws high
    first = -1;
    for (int n = 0; n < 24; n++) begin
      raw[5] = 1'b1;
      cycle(1'b0, (n % 4) == 3);
      if (WS && first < 0) first = n;
    end
    chk("t5_ws_rise_at", 16'(first), 16'd15);

    // 6: all high, then a single reset cycle restarts warm-up
    raw = 7'h7f;
    for (int n = 0; n < 12; n++) cycle(1'b0, 1'b1);
    chk("t6_all_high", {7'd0, ready, ack_pulse, ACK, WS, IM, CS, OC, HS, ST}, 16'h17f);
    cycle(1'b1, 1'b1);
    chk("t6_after_rst", {7'd0, ready, ack_pulse, ACK, WS, IM, CS, OC, HS, ST}, 16'h000);
    first = -1;
    for (int n = 1; n <= 18; n++) begin
      cycle(1'b0, 1'b1);
      if (ready && first < 0) first = n;
    end
    chk("t6_rewarm_at", 16'(first), 16'd15);

    // random stimulus against the model
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
